// File: rtl/uart_fpga_pkg.sv
// ============================================================================
// Package     : uart_fpga_pkg
// Description : Shared definitions for the FPGA UART TX/RX pair: FSM state
//               encodings, parity-mode encodings and the bit-period helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_fpga_pkg;

  typedef logic [2:0] uart_state_t;

  // FSM state encodings. Codes 6 and 7 are unused and recover to IDLE.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // System clocks per serial bit (integer divide).
  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous serial line.
//               Both flops preset to 1 so the line reads idle out of reset.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input
//               q     - synchronised output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_fpga_rx.sv
// ============================================================================
// Module      : uart_fpga_rx
// Description : UART receiver. Synchronises the serial line, qualifies the
//               start bit at half a bit period, samples data/parity/stop bits
//               mid-slot and presents the word with a 1-cycle valid strobe.
// Ports       : IN_CLOCK         - system clock
//               IN_RESET_N       - asynchronous active-low reset
//               IN_RX_SERIAL     - async serial line, idle high
//               OUT_RX_DATA      - last received word, held until next valid
//               OUT_RX_VALID     - 1-cycle strobe, data and error flags updated
//               OUT_RX_ACTIVE    - high from start-bit confirm to frame end
//               OUT_PARITY_ERROR - parity mismatch, qualified by OUT_RX_VALID
//               OUT_FRAME_ERROR  - a stop bit sampled low, qualified by valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fpga_rx
  import uart_fpga_pkg::*;
#(
  parameter int UART_BAUD_RATE           = 9600,
  parameter int CLOCK_FREQUENCY          = 50000000,
  parameter int PARITY                   = 1,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int NUMBER_STOP_BITS         = 2
) (
  input  logic                                IN_CLOCK,
  input  logic                                IN_RESET_N,
  input  logic                                IN_RX_SERIAL,
  output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RX_DATA,
  output logic                                OUT_RX_VALID,
  output logic                                OUT_RX_ACTIVE,
  output logic                                OUT_PARITY_ERROR,
  output logic                                OUT_FRAME_ERROR
);

  localparam int N     = NUM_OF_DATA_BITS_IN_PACK;
  localparam int CPB   = clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
  localparam int CNT_W = $clog2(CPB) + 1;
  localparam int IDX_W = $clog2(N) + 1;

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1    = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [1:0]       LAST_STOP = 2'(NUMBER_STOP_BITS - 1);
  // Odd parity expects the XOR of data and parity bit to be 1, so an
  // odd-mode error is the even-mode error inverted.
  localparam logic             ODD_MODE  = (PARITY == PARITY_ODD);
  localparam logic             HAS_PAR   = (PARITY != PARITY_NONE);

  logic             rx_s;
  uart_state_t      state;
  logic [CNT_W-1:0] clk_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [1:0]       stop_idx;
  logic [N-1:0]     shift_reg;
  logic             par_err;
  logic             frm_err;

  uart_rx_sync u_sync (
    .clk   (IN_CLOCK),
    .rst_n (IN_RESET_N),
    .d     (IN_RX_SERIAL),
    .q     (rx_s)
  );

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state            <= ST_IDLE;
      clk_cnt          <= '0;
      bit_idx          <= '0;
      stop_idx         <= '0;
      shift_reg        <= '0;
      par_err          <= 1'b0;
      frm_err          <= 1'b0;
      OUT_RX_DATA      <= '0;
      OUT_RX_VALID     <= 1'b0;
      OUT_RX_ACTIVE    <= 1'b0;
      OUT_PARITY_ERROR <= 1'b0;
      OUT_FRAME_ERROR  <= 1'b0;
    end else begin
      OUT_RX_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            clk_cnt <= '0;
            state   <= ST_START;
          end
        end

        ST_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;          // glitch, not a real start bit
            end else begin
              OUT_RX_ACTIVE <= 1'b1;
              bit_idx       <= '0;
              par_err       <= 1'b0;
              frm_err       <= 1'b0;
              state         <= ST_DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            // LSB arrives first; shifting in at the top leaves bit 0 in
            // position 0 after N samples.
            shift_reg <= {rx_s, shift_reg[N-1:1]};
            if (bit_idx == LAST_IDX) begin
              bit_idx  <= '0;
              stop_idx <= '0;
              state    <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            par_err <= (^shift_reg) ^ rx_s ^ ODD_MODE;
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (clk_cnt == BIT_M1) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              frm_err <= 1'b1;
            end
            if (stop_idx == LAST_STOP) begin
              stop_idx <= '0;
              state    <= ST_DONE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          OUT_RX_DATA      <= shift_reg;
          OUT_PARITY_ERROR <= par_err;
          OUT_FRAME_ERROR  <= frm_err;
          OUT_RX_VALID     <= 1'b1;
          OUT_RX_ACTIVE    <= 1'b0;
          state            <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_fpga_rx.sv
// ============================================================================
// Module      : tb_uart_fpga_rx
// Description : Self-checking bench for uart_fpga_rx. Three receivers share
//               one clock: even parity / 2 stop, odd parity / 2 stop and no
//               parity / 1 stop. CLKS_PER_BIT = 16, clock period 100 units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fpga_rx;

  localparam int BIT_T = 1600;   // 16 clocks of 100 units
  localparam int L_E = 0;        // even parity, 2 stop bits
  localparam int L_O = 1;        // odd parity, 2 stop bits
  localparam int L_N = 2;        // no parity, 1 stop bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_e = 1'b1, rx_o = 1'b1, rx_n = 1'b1;

  logic [7:0] d_e, d_o, d_n;
  logic       v_e, v_o, v_n, a_e, a_o, a_n;
  logic       pe_e, pe_o, pe_n, fe_e, fe_o, fe_n;

  int total = 0;
  int bad = 0;

  logic [9:0] q_e[$];
  logic [9:0] q_o[$];
  logic [9:0] q_n[$];

  always #50 clk = ~clk;

  uart_fpga_rx #(.UART_BAUD_RATE(10), .CLOCK_FREQUENCY(160), .PARITY(1),
                 .NUM_OF_DATA_BITS_IN_PACK(8), .NUMBER_STOP_BITS(2)) dut_e (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_RX_SERIAL(rx_e),
    .OUT_RX_DATA(d_e), .OUT_RX_VALID(v_e), .OUT_RX_ACTIVE(a_e),
    .OUT_PARITY_ERROR(pe_e), .OUT_FRAME_ERROR(fe_e));

  uart_fpga_rx #(.UART_BAUD_RATE(10), .CLOCK_FREQUENCY(160), .PARITY(2),
                 .NUM_OF_DATA_BITS_IN_PACK(8), .NUMBER_STOP_BITS(2)) dut_o (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_RX_SERIAL(rx_o),
    .OUT_RX_DATA(d_o), .OUT_RX_VALID(v_o), .OUT_RX_ACTIVE(a_o),
    .OUT_PARITY_ERROR(pe_o), .OUT_FRAME_ERROR(fe_o));

  uart_fpga_rx #(.UART_BAUD_RATE(10), .CLOCK_FREQUENCY(160), .PARITY(0),
                 .NUM_OF_DATA_BITS_IN_PACK(8), .NUMBER_STOP_BITS(1)) dut_n (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_RX_SERIAL(rx_n),
    .OUT_RX_DATA(d_n), .OUT_RX_VALID(v_n), .OUT_RX_ACTIVE(a_n),
    .OUT_PARITY_ERROR(pe_n), .OUT_FRAME_ERROR(fe_n));

  // Strobe monitor: record {data, parity_err, frame_err} on every valid.
  always @(negedge clk) begin
    if (v_e) q_e.push_back({d_e, pe_e, fe_e});
    if (v_o) q_o.push_back({d_o, pe_o, fe_o});
    if (v_n) q_n.push_back({d_n, pe_n, fe_n});
  end

  typedef struct {
    string      name;
    int         line;
    logic [7:0] data;
    bit         flip_par;
    bit         stop2_low;
    int         bit_t;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int line, input logic v);
    case (line)
      L_E:     rx_e = v;
      L_O:     rx_o = v;
      default: rx_n = v;
    endcase
  endtask

  function automatic int qsize(input int line);
    case (line)
      L_E:     return q_e.size();
      L_O:     return q_o.size();
      default: return q_n.size();
    endcase
  endfunction

  task automatic pop(input int line, output logic [9:0] r);
    case (line)
      L_E:     r = q_e.pop_front();
      L_O:     r = q_o.pop_front();
      default: r = q_n.pop_front();
    endcase
  endtask

  // Transmitter model: start, 8 data bits LSB first, parity, stop bits.
  task automatic send(input int line, input logic [7:0] d, input bit flip_par,
                      input bit stop2_low, input int bt);
    int  pmode;
    int  nstop;
    logic p;
    pmode = (line == L_E) ? 1 : (line == L_O) ? 2 : 0;
    nstop = (line == L_N) ? 1 : 2;
    set_line(line, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      set_line(line, d[i]);
      #(bt);
    end
    if (pmode != 0) begin
      p = (pmode == 1) ? ^d : ~(^d);
      set_line(line, p ^ flip_par);
      #(bt);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(line, !(stop2_low && s == 1));
      #(bt);
    end
    set_line(line, 1'b1);
  endtask

  task automatic check_rec(input string name, input int line, input logic [7:0] ed,
                           input bit epe, input bit efe);
    logic [9:0] r;
    if (qsize(line) > 0) begin
      pop(line, r);
      chk({name, " data"}, {24'd0, r[9:2]}, {24'd0, ed});
      chk({name, " parity_err"}, {31'd0, r[1]}, {31'd0, epe});
      chk({name, " frame_err"}, {31'd0, r[0]}, {31'd0, efe});
    end
  endtask

  initial begin
    logic act_hi;

    vecs[0] = '{"even A5",        L_E, 8'hA5, 1'b0, 1'b0, BIT_T, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{"even 01 badpar", L_E, 8'h01, 1'b1, 1'b0, BIT_T, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{"even 3C stop2lo",L_E, 8'h3C, 1'b0, 1'b1, BIT_T, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{"even 5A",        L_E, 8'h5A, 1'b0, 1'b0, BIT_T, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{"none C3 +3pct",  L_N, 8'hC3, 1'b0, 1'b0, 1648,  8'hC3, 1'b0, 1'b0};
    vecs[5] = '{"none C3 -3pct",  L_N, 8'hC3, 1'b0, 1'b0, 1552,  8'hC3, 1'b0, 1'b0};
    vecs[6] = '{"odd 81",         L_O, 8'h81, 1'b0, 1'b0, BIT_T, 8'h81, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset data", {24'd0, d_e}, 32'd0);
    chk("reset valid", {31'd0, v_e}, 32'd0);
    chk("reset active", {31'd0, a_e}, 32'd0);
    chk("reset parity_err", {31'd0, pe_e}, 32'd0);
    chk("reset frame_err", {31'd0, fe_e}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven single frames
    for (int k = 0; k < 7; k++) begin
      send(vecs[k].line, vecs[k].data, vecs[k].flip_par, vecs[k].stop2_low, vecs[k].bit_t);
      repeat (30) @(negedge clk);
      chk({vecs[k].name, " strobes"}, qsize(vecs[k].line), 32'd1);
      check_rec(vecs[k].name, vecs[k].line, vecs[k].exp_data, vecs[k].exp_perr, vecs[k].exp_ferr);
      while (qsize(vecs[k].line) > 0) begin
        logic [9:0] junk;
        pop(vecs[k].line, junk);
      end
      repeat (5) @(negedge clk);
    end

    // Back-to-back frames with no idle gap, odd parity
    send(L_O, 8'h00, 1'b0, 1'b0, BIT_T);
    send(L_O, 8'hFF, 1'b0, 1'b0, BIT_T);
    send(L_O, 8'h3C, 1'b0, 1'b0, BIT_T);
    repeat (30) @(negedge clk);
    chk("b2b strobes", qsize(L_O), 32'd3);
    check_rec("b2b 00", L_O, 8'h00, 1'b0, 1'b0);
    check_rec("b2b FF", L_O, 8'hFF, 1'b0, 1'b0);
    check_rec("b2b 3C", L_O, 8'h3C, 1'b0, 1'b0);

    // 5-cycle glitch on an idle line
    set_line(L_E, 1'b0);
    repeat (5) @(negedge clk);
    set_line(L_E, 1'b1);
    act_hi = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_e) act_hi = 1'b1;
    end
    chk("glitch active", {31'd0, act_hi}, 32'd0);
    chk("glitch strobes", qsize(L_E), 32'd0);

    // Reset in the middle of data bit 3 (line holds bits of A5)
    set_line(L_E, 1'b0);
    #(BIT_T);
    set_line(L_E, 1'b1); #(BIT_T);   // bit0 of A5
    set_line(L_E, 1'b0); #(BIT_T);   // bit1
    set_line(L_E, 1'b1); #(BIT_T);   // bit2
    set_line(L_E, 1'b0); #(BIT_T / 2 + 20); // half of bit3
    chk("midframe active", {31'd0, a_e}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset data", {24'd0, d_e}, 32'd0);
    chk("midreset active", {31'd0, a_e}, 32'd0);
    chk("midreset valid", {31'd0, v_e}, 32'd0);
    chk("midreset parity_err", {31'd0, pe_e}, 32'd0);
    chk("midreset frame_err", {31'd0, fe_e}, 32'd0);
    set_line(L_E, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset strobes", qsize(L_E), 32'd0);
    send(L_E, 8'h5A, 1'b0, 1'b0, BIT_T);
    repeat (30) @(negedge clk);
    chk("post-reset strobes", qsize(L_E), 32'd1);
    check_rec("post-reset 5A", L_E, 8'h5A, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #(20_000_000);
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
